apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-outstanding APB4 initiator: converts a valid/ready request/response port into APB SETUP/ACCESS transfers.
- Sits upstream of APB responders such as the GPIO APB wrapper; used by DMA-less controllers and testbenches to drive peripheral register files.
- A per-transfer timeout counter terminates hung transfers with an error response.

Parameters:
- ADDR_WIDTH, 32, width of paddr_o / req_addr_i.
- DATA_WIDTH, 32, width of data buses; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, max ACCESS-phase cycles before abort; 0 disables timeout.
- STRB_WIDTH, DATA_WIDTH/8, localparam.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_write_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_wstrb_i  in  STRB_WIDTH  write byte strobes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_error_o  out  1  pslverr or timeout.
- rsp_timeout_o  out  1  error caused by timeout.
- paddr_o  out  ADDR_WIDTH  APB address.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  STRB_WIDTH  APB strobes; forced 0 on reads.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB error.

Behaviour:
- Reset values (while rst_i high and after release):
  - state IDLE.
  - psel_o, penable_o, pwrite_o = 0; paddr_o, pwdata_o, pstrb_o = 0.
  - rsp_valid_o, rsp_error_o, rsp_timeout_o = 0; rsp_rdata_o = 0.
  - req_ready_o = 1.
- FSM states IDLE, SETUP, ACCESS, RESP:
  - IDLE: req_ready_o = 1. On req_valid_i & req_ready_o, latch addr/write/wdata/wstrb into APB output registers (pstrb = 0 if read) and go to SETUP.
  - SETUP: psel_o = 1, penable_o = 0, for exactly one cycle, then ACCESS.
  - ACCESS: psel_o = 1, penable_o = 1.
    - On pready_i: capture prdata_i (reads only, else 0), rsp_error_o = pslverr_i, rsp_timeout_o = 0, then RESP.
    - Otherwise increment the timeout counter.
    - If TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1 with pready_i low: rsp_error_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0, then RESP.
    - If pready_i and timeout occur in the same cycle, pready_i wins.
  - RESP: psel_o = penable_o = 0; rsp_valid_o = 1. Response fields are held stable until rsp_ready_i; then go to IDLE.
- req_ready_o is low in SETUP, ACCESS and RESP; only one transfer is outstanding at a time.
- paddr_o, pwrite_o, pwdata_o and pstrb_o are stable from SETUP through the final ACCESS cycle. They keep their last value in RESP/IDLE; they are not cleared.
- Timeout counter:
  - width $clog2(TIMEOUT_CYCLES+1).
  - cleared on entry to ACCESS.
  - saturates; never wraps.
- Latency:
  - request accepted at edge N; SETUP in cycle N+1; ACCESS from N+2.
  - pready_i high in N+2 gives rsp_valid_o in N+3.
  - minimum 4 cycles per transfer, IDLE included.
- rst_i asserted mid-transfer: all outputs return to reset values immediately (asynchronous). Any in-flight APB transfer is dropped and no response is issued.
- req_* inputs are ignored outside IDLE. rsp_ready_i is ignored outside RESP.

Test Plan:
- Write 0x1000_0004 = 0xDEAD_BEEF, wstrb 0xF, responder pready immediate:
  - N+1: psel=1, penable=0.
  - N+2: penable=1, pstrb=0xF.
  - N+3: rsp_valid=1, error=0, rdata=0.
- Read 0x1000_0008, responder inserts 3 wait states, prdata 0x0000_00A5 on the ready cycle:
  - ACCESS lasts 4 cycles; rsp_rdata=0xA5; pstrb=0 throughout.
- Responder returns pslverr=1 on a read:
  - rsp_error=1, rsp_timeout=0, rdata=prdata value.
- TIMEOUT_CYCLES=8, pready held low:
  - abort after 8 ACCESS cycles; psel drops; rsp_error=1, rsp_timeout=1, rdata=0.
  - a following request completes normally.
- Response backpressure: rsp_ready=0 for 5 cycles with req_valid held high:
  - rsp fields stable; req_ready=0.
  - next transfer's SETUP starts 2 cycles after the rsp handshake cycle.
- rst_i pulsed during ACCESS:
  - psel/penable/rsp_valid go 0 asynchronously; req_ready=1 after release; no spurious response.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//
// Single-outstanding APB4 initiator. A valid/ready request port is turned into one
// APB SETUP + ACCESS transfer; the result is returned on a valid/ready response port.
// ACCESS phases that run too long are aborted with an error/timeout response.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   req_valid_i/ready_o  request handshake; ready only while idle
//   req_addr_i           byte address
//   req_write_i          1 = write, 0 = read
//   req_wdata_i          write data
//   req_wstrb_i          write byte strobes
//   rsp_valid_o/ready_i  response handshake; fields held until consumed
//   rsp_rdata_o          read data (0 for writes and timeouts)
//   rsp_error_o          pslverr or timeout
//   rsp_timeout_o        error was caused by timeout
//   paddr_o .. pstrb_o   APB requester outputs
//   prdata_i, pready_i,
//   pslverr_i            APB completer inputs
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_wstrb_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic                  rsp_timeout_o,

    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    // A zero timeout still needs a legal (unused) one-bit counter.
    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    pstrb_d  = req_write_i ? req_wstrb_i : '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                // pready takes priority over a timeout landing in the same cycle.
                if (pready_i) begin
                    rdata_d   = pwrite_q ? '0 : prdata_i;
                    error_d   = pslverr_i;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d   = '0;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake and strobe outputs decode the state register directly so that an
    // asynchronous reset clears them without waiting for a clock edge.
    assign req_ready_o   = (state_q == StIdle);
    assign psel_o        = (state_q == StSetup) || (state_q == StAccess);
    assign penable_o     = (state_q == StAccess);
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_error_o   = error_q;
    assign rsp_timeout_o = timeout_q;
    assign paddr_o       = paddr_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_write_i  (req_write),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_error_o  (rsp_error),
        .rsp_timeout_o(rsp_timeout),
        .paddr_o      (paddr),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .pwdata_o     (pwdata),
        .pstrb_o      (pstrb),
        .prdata_i     (prdata),
        .pready_i     (pready),
        .pslverr_i    (pslverr)
    );

    // One complete transfer, started at a falling edge while the bridge is idle.
    // The responder answers after `waits` wait states; waits >= TO means it never
    // answers. Expectations come from the transfer-level rules, not the FSM.
    task automatic test_xfer(input string name, input logic [AW-1:0] addr, input logic wr,
                             input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                             input int waits, input logic slverr, input logic [DW-1:0] rdata,
                             input int rsp_delay, input bit hold_valid);
        logic [SW-1:0] exp_strb;
        logic          exp_to;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
        int            n_access;
        exp_strb  = wr ? wstrb : '0;
        exp_to    = (waits >= int'(TO));
        exp_err   = exp_to ? 1'b1 : slverr;
        exp_rdata = (exp_to || wr) ? '0 : rdata;
        n_access  = exp_to ? int'(TO) : waits + 1;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wdata;
        req_wstrb = wstrb;

        // SETUP
        @(negedge clk);
        req_valid = hold_valid;
        req_addr  = $urandom;
        req_write = 1'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        rsp_ready = 1'($urandom);
        checks++;
        if ({psel, penable, req_ready, rsp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL %s setup_ctrl: got %b want 1000", name,
                     {psel, penable, req_ready, rsp_valid});
        end
        checks++;
        if ({paddr, pwrite, pwdata, pstrb} !== {addr, wr, wdata, exp_strb}) begin
            errors++;
            $display("FAIL %s setup_fields: got %h/%b/%h/%h want %h/%b/%h/%h", name,
                     paddr, pwrite, pwdata, pstrb, addr, wr, wdata, exp_strb);
        end

        // ACCESS
        for (int k = 0; k < n_access; k++) begin
            @(negedge clk);
            rsp_ready = 1'($urandom);
            checks++;
            if ({psel, penable, req_ready, rsp_valid} !== 4'b1100) begin
                errors++;
                $display("FAIL %s access%0d_ctrl: got %b want 1100", name, k,
                         {psel, penable, req_ready, rsp_valid});
            end
            checks++;
            if ({paddr, pwrite, pwdata, pstrb} !== {addr, wr, wdata, exp_strb}) begin
                errors++;
                $display("FAIL %s access%0d_fields: got %h/%b/%h/%h want %h/%b/%h/%h", name, k,
                         paddr, pwrite, pwdata, pstrb, addr, wr, wdata, exp_strb);
            end
            pready  = (k == waits);
            prdata  = (k == waits) ? rdata : $urandom;
            pslverr = (k == waits) ? slverr : 1'($urandom);
        end

        // RESP
        @(negedge clk);
        pready    = 1'b0;
        prdata    = $urandom;
        pslverr   = 1'($urandom);
        rsp_ready = (rsp_delay == 0);
        checks++;
        if ({psel, penable, req_ready, rsp_valid} !== 4'b0001) begin
            errors++;
            $display("FAIL %s resp_ctrl: got %b want 0001", name,
                     {psel, penable, req_ready, rsp_valid});
        end
        checks++;
        if ({rsp_rdata, rsp_error, rsp_timeout} !== {exp_rdata, exp_err, exp_to}) begin
            errors++;
            $display("FAIL %s resp_fields: got %h/%b/%b want %h/%b/%b", name,
                     rsp_rdata, rsp_error, rsp_timeout, exp_rdata, exp_err, exp_to);
        end
        checks++;
        if ({paddr, pwrite, pwdata, pstrb} !== {addr, wr, wdata, exp_strb}) begin
            errors++;
            $display("FAIL %s resp_apb_kept: got %h/%b/%h/%h want %h/%b/%h/%h", name,
                     paddr, pwrite, pwdata, pstrb, addr, wr, wdata, exp_strb);
        end
        for (int d = 0; d < rsp_delay; d++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout} !==
                {1'b0, 1'b1, exp_rdata, exp_err, exp_to}) begin
                errors++;
                $display("FAIL %s resp_hold%0d: got %b/%b/%h/%b/%b want 0/1/%h/%b/%b", name, d,
                         req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
                         exp_rdata, exp_err, exp_to);
            end
            if (d == rsp_delay - 1) rsp_ready = 1'b1;
        end

        // Back in IDLE one cycle after the handshake.
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({psel, penable, req_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL %s post_idle: got %b want 0010", name,
                     {psel, penable, req_ready, rsp_valid});
        end
        if (!hold_valid) req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
            errors++;
            $display("FAIL reset_apb: got %b%b%b %h %h %h want all 0",
                     psel, penable, pwrite, paddr, pwdata, pstrb);
        end
        checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 35'd0}) begin
            errors++;
            $display("FAIL reset_rsp: got %b%b%b%b %h want 1000 0",
                     req_ready, rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, psel, penable} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release: got %b want 1000", {req_ready, rsp_valid, psel, penable});
        end
    endtask

    task automatic test_write_immediate();
        test_xfer("wr_imm", 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_read_waits();
        test_xfer("rd_wait", 32'h1000_0008, 1'b0, 32'h5555_AAAA, 4'hF, 3, 1'b0, 32'h0000_00A5,
                  1, 1'b0);
    endtask

    task automatic test_slverr();
        test_xfer("rd_err", 32'h1000_0010, 1'b0, 32'h0, 4'h3, 1, 1'b1, 32'h1234_5678, 0, 1'b0);
        test_xfer("wr_err", 32'h1000_0014, 1'b1, 32'hCAFE_F00D, 4'h6, 2, 1'b1, 32'hFFFF_FFFF,
                  0, 1'b0);
    endtask

    task automatic test_timeout();
        test_xfer("timeout", 32'h2000_0000, 1'b0, 32'h0, 4'h0, 100, 1'b0, 32'h0, 0, 1'b0);
        test_xfer("after_to", 32'h2000_0004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_CAFE, 0, 1'b0);
        // Responder answers in the very cycle the timeout would fire.
        test_xfer("to_edge", 32'h2000_0008, 1'b0, 32'h0, 4'h0, int'(TO) - 1, 1'b0,
                  32'h7777_0001, 0, 1'b0);
        test_xfer("to_wr", 32'h2000_000C, 1'b1, 32'h1111_2222, 4'hF, int'(TO), 1'b0,
                  32'h0, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_xfer("bp_first", 32'h3000_0000, 1'b1, 32'hA5A5_5A5A, 4'hC, 0, 1'b0, 32'h0, 5, 1'b1);
        test_xfer("bp_next", 32'h3000_0004, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0000_3C3C, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_addr  = 32'h4000_0000;
        req_write = 1'b1;
        req_wdata = 32'h0F0F_0F0F;
        req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_access: got %b want 11", {psel, penable});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_async: got %b want 0001", {psel, penable, rsp_valid, req_ready});
        end
        checks++;
        if ({paddr, pwdata, pstrb, pwrite} !== '0) begin
            errors++;
            $display("FAIL rst_mid_fields: got %h/%h/%h/%b want 0", paddr, pwdata, pstrb, pwrite);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rsp_ready = 1'($urandom);
            pready    = 1'($urandom);
            checks++;
            if ({psel, penable, rsp_valid, req_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL rst_mid_after%0d: got %b want 0001", c,
                         {psel, penable, rsp_valid, req_ready});
            end
        end
        rsp_ready = 1'b0;
        pready    = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            test_xfer($sformatf("rand%0d", i), $urandom, 1'($urandom), $urandom, 4'($urandom),
                      int'($urandom_range(0, 10)), 1'($urandom), $urandom,
                      int'($urandom_range(0, 3)), (i != 29) && ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_write_immediate();
        test_read_waits();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
